// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus of the operand sequencer: registered operands/selects out, combinational
// result and flags back. The sequencer uses the master view, the ALU (or a model) the slave view.
interface alu_operand_sequencer_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [1:0]        OP_Selector;
    logic [1:0]        Shift_Selector;
    logic [1:0]        Shift_Right;
    logic [1:0]        Shift_Left;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;

    modport master (
        output A, B, OP_Selector, Shift_Selector, Shift_Right, Shift_Left,
        input  alu_res, alu_flags
    );

    modport slave (
        input  A, B, OP_Selector, Shift_Selector, Shift_Right, Shift_Left,
        output alu_res, alu_flags
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-stepped front-end for the 4-bit ALU: loads A, B, selects and shifts, then captures result/flags.
// Optional DEBOUNCE_EN macro inserts a level-acceptance counter after the button synchronizer.
module alu_operand_sequencer #(
    parameter int DATA_W          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     sw,
    input  logic                  btn_next,
    input  logic                  btn_clear,
    alu_operand_sequencer_if.master alu,
    output logic                  run_pulse,
    output logic [DATA_W-1:0]     res_q,
    output logic [3:0]            flags_q,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_LOAD_SH = 3'd3,
        S_RUN     = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   ld_a, ld_b, ld_op, ld_sh, cap;

    // Stage 0: metastability synchronizer for the raw button
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   btn_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_p0 <= '0;
        else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_next};
    end
    assign btn_sync = sync_p0[SYNC_STAGES-1];

    // Stage 1: accepted button level
    logic level_p1;
`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] db_cnt;

    // Counter only runs while the synchronized level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            level_p1 <= 1'b0;
        end else if (btn_sync == level_p1) begin
            db_cnt   <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            level_p1 <= btn_sync;
        end else begin
            db_cnt   <= db_cnt + CNT_W'(1);
        end
    end
`else
    assign level_p1 = btn_sync;
`endif

    // Stage 2: rising-edge detect gives one event per press
    logic level_p2;
    logic press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_p2 <= 1'b0;
        else     level_p2 <= level_p1;
    end
    assign press = level_p1 & ~level_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_LOAD_A;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        ld_sh     = 1'b0;
        cap       = 1'b0;
        run_pulse = (state_q == S_RUN);
        if (btn_clear) begin
            state_d = S_LOAD_A;
        end else begin
            case (state_q)
                S_LOAD_A:  if (press) begin ld_a  = 1'b1; state_d = S_LOAD_B;  end
                S_LOAD_B:  if (press) begin ld_b  = 1'b1; state_d = S_LOAD_OP; end
                S_LOAD_OP: if (press) begin ld_op = 1'b1; state_d = S_LOAD_SH; end
                S_LOAD_SH: if (press) begin ld_sh = 1'b1; state_d = S_RUN;     end
                S_RUN:     begin cap = 1'b1; state_d = S_HOLD; end
                S_HOLD:    if (press) state_d = S_LOAD_A;
                default:   state_d = S_LOAD_A;
            endcase
        end
    end

    // Clear wins over any load or capture in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst || btn_clear) begin
            alu.A              <= '0;
            alu.B              <= '0;
            alu.OP_Selector    <= '0;
            alu.Shift_Selector <= '0;
            alu.Shift_Right    <= '0;
            alu.Shift_Left     <= '0;
            res_q              <= '0;
            flags_q            <= '0;
        end else begin
            if (ld_a) alu.A <= sw;
            if (ld_b) alu.B <= sw;
            if (ld_op) begin
                alu.OP_Selector    <= sw[1:0];
                alu.Shift_Selector <= sw[3:2];
            end
            if (ld_sh) begin
                alu.Shift_Right <= sw[1:0];
                alu.Shift_Left  <= sw[3:2];
            end
            if (cap) begin
                res_q   <= alu.alu_res;
                flags_q <= alu.alu_flags;
            end
        end
    end

    assign state_o = state_q;

endmodule
